// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int          FETCH_PC_W   = 64;
    localparam int          FETCH_INST_W = 32;
    localparam logic [63:0] PC_RST_VAL   = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_KEEP  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2,
        PC_PEND  = 2'd3
    } pc_sel_e;

endpackage
`default_nettype wire

// File: rtl/ifu_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pc_gen
// Description : Fetch PC and pending-redirect registers with next-PC mux.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_pc_gen
    import cpu_pkg::*;
#(
    parameter int              PC_W   = FETCH_PC_W,
    parameter logic [PC_W-1:0] PC_RST = PC_W'(PC_RST_VAL)
) (
    input  logic            clk,
    input  logic            rst,
    input  pc_sel_e         pc_sel_i,
    input  logic            pend_load_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic [PC_W-1:0] pc_o,
    output logic            pc_misaligned_o,
    output logic            pc_d_misaligned_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pend_pc_q;
    logic [PC_W-1:0] pend_pc_d;

    always_comb begin
        pc_d = pc_q;
        case (pc_sel_i)
            PC_INC:   pc_d = pc_q + PC_W'(4);
            PC_REDIR: pc_d = redirect_pc_i;
            PC_PEND:  pc_d = pend_pc_q;
            default:  pc_d = pc_q;
        endcase
    end

    assign pend_pc_d = pend_load_i ? redirect_pc_i : pend_pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= PC_RST;
            pend_pc_q <= '0;
        end else begin
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign pc_o              = pc_q;
    assign pc_misaligned_o   = (pc_q[1:0] != 2'b00);
    // Lets the FSM register ar_valid for the PC it is about to present.
    assign pc_d_misaligned_o = (pc_d[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch
// Description : Single-outstanding instruction fetch unit with redirect support.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch
    import cpu_pkg::*;
#(
    parameter int              PC_W   = FETCH_PC_W,
    parameter int              INST_W = FETCH_INST_W,
    parameter logic [PC_W-1:0] PC_RST = PC_W'(PC_RST_VAL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_ar_valid,
    input  logic              imem_ar_ready,
    output logic [PC_W-1:0]   imem_ar_addr,
    input  logic              imem_r_valid,
    output logic              imem_r_ready,
    input  logic [INST_W-1:0] imem_r_data,
    input  logic              imem_r_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              out_fault
);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic              ar_valid_q;
    logic              r_ready_q;
    logic              out_valid_q;
    logic              out_fault_q;
    logic [PC_W-1:0]   out_pc_q;
    logic [INST_W-1:0] out_inst_q;

    pc_sel_e           pc_sel;
    logic              pend_load;
    logic              capture_beat;
    logic              capture_fault;
    logic              ar_hs;
    logic [PC_W-1:0]   pc;
    logic              pc_misaligned;
    logic              pc_d_misaligned;

    ifu_pc_gen #(
        .PC_W   (PC_W),
        .PC_RST (PC_RST)
    ) u_pc_gen (
        .clk               (clk),
        .rst               (rst),
        .pc_sel_i          (pc_sel),
        .pend_load_i       (pend_load),
        .redirect_pc_i     (redirect_pc),
        .pc_o              (pc),
        .pc_misaligned_o   (pc_misaligned),
        .pc_d_misaligned_o (pc_d_misaligned)
    );

    assign ar_hs = ar_valid_q && imem_ar_ready;

    always_comb begin
        state_d       = state_q;
        pc_sel        = PC_KEEP;
        pend_load     = 1'b0;
        capture_beat  = 1'b0;
        capture_fault = 1'b0;
        case (state_q)
            REQ: begin
                if (ar_hs) begin
                    pend_load = redirect_valid;
                    state_d   = redirect_valid ? DRAIN : WAIT;
                end else if (redirect_valid) begin
                    pc_sel = PC_REDIR;
                end else if (pc_misaligned) begin
                    state_d       = HOLD;
                    capture_fault = 1'b1;
                end
            end
            WAIT: begin
                // A beat consumed together with a redirect leaves nothing in
                // flight, so there is nothing left to drain.
                if (redirect_valid && imem_r_valid) begin
                    state_d = REQ;
                    pc_sel  = PC_REDIR;
                end else if (redirect_valid) begin
                    state_d   = DRAIN;
                    pend_load = 1'b1;
                end else if (imem_r_valid) begin
                    state_d      = HOLD;
                    capture_beat = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    state_d = REQ;
                    pc_sel  = PC_REDIR;
                end else if (out_ready) begin
                    state_d = REQ;
                    pc_sel  = PC_INC;
                end
            end
            DRAIN: begin
                if (imem_r_valid) begin
                    state_d = REQ;
                    if (redirect_valid) begin
                        pc_sel = PC_REDIR;
                    end else begin
                        pc_sel = PC_PEND;
                    end
                end else if (redirect_valid) begin
                    pend_load = 1'b1;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= REQ;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
            out_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ar_valid_q  <= (state_d == REQ) && !pc_d_misaligned;
            r_ready_q   <= (state_d == WAIT) || (state_d == DRAIN);
            out_valid_q <= (state_d == HOLD);
            if (capture_beat) begin
                out_pc_q    <= pc;
                out_fault_q <= imem_r_err;
                out_inst_q  <= imem_r_err ? '0 : imem_r_data;
            end else if (capture_fault) begin
                out_pc_q    <= pc;
                out_fault_q <= 1'b1;
                out_inst_q  <= '0;
            end
        end
    end

    assign imem_ar_valid = ar_valid_q;
    assign imem_ar_addr  = pc;
    assign imem_r_ready  = r_ready_q;
    assign out_valid     = out_valid_q;
    assign out_pc        = out_pc_q;
    assign out_inst      = out_inst_q;
    assign out_fault     = out_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch
// Description : Self-checking bench for ifu_fetch with memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_ar_valid;
    logic        imem_ar_ready;
    logic [63:0] imem_ar_addr;
    logic        imem_r_valid;
    logic        imem_r_ready;
    logic [31:0] imem_r_data;
    logic        imem_r_err;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_ar_valid  (imem_ar_valid),
        .imem_ar_ready  (imem_ar_ready),
        .imem_ar_addr   (imem_ar_addr),
        .imem_r_valid   (imem_r_valid),
        .imem_r_ready   (imem_r_ready),
        .imem_r_data    (imem_r_data),
        .imem_r_err     (imem_r_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_fault      (out_fault)
    );

    int checks = 0;
    int errors = 0;

    bit          rand_mem    = 1'b0;
    bit          err_rand_en = 1'b0;
    int          mem_delay   = 0;
    logic [63:0] err_addr    = '1;

    function automatic logic [31:0] memf(input logic [63:0] a);
        return a[31:0] ^ {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic bit errf(input logic [63:0] a);
        return (a == err_addr) || (err_rand_en && (a[6:2] == 5'd13));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: one outstanding read, configurable latency.
    bit          s_ar_hs, s_r_hs;
    logic [63:0] s_addr;
    bit          m_out;
    logic [63:0] m_addr;
    int          m_cnt;

    always @(negedge clk) begin
        s_ar_hs = imem_ar_valid && imem_ar_ready;
        s_r_hs  = imem_r_valid && imem_r_ready;
        s_addr  = imem_ar_addr;
    end

    initial begin
        imem_ar_ready = 1'b1;
        imem_r_valid  = 1'b0;
        imem_r_data   = '0;
        imem_r_err    = 1'b0;
        m_out         = 1'b0;
        m_addr        = '0;
        m_cnt         = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                m_out        = 1'b0;
                imem_r_valid = 1'b0;
            end else begin
                if (s_r_hs) begin
                    m_out        = 1'b0;
                    imem_r_valid = 1'b0;
                end
                if (s_ar_hs) begin
                    m_out  = 1'b1;
                    m_addr = s_addr;
                    m_cnt  = rand_mem ? int'($urandom_range(0, 3)) : mem_delay;
                end
                if (m_out && !imem_r_valid) begin
                    if (m_cnt == 0) begin
                        imem_r_valid = 1'b1;
                        imem_r_data  = memf(m_addr);
                        imem_r_err   = errf(m_addr);
                    end else begin
                        m_cnt--;
                    end
                end
            end
            imem_ar_ready = rand_mem ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Reference model: the architectural next-fetch PC and the single
    // outstanding request, checked against the DUT every cycle.
    logic [63:0] exp_pc;
    bit          outst;
    int          idle;
    bit          p_hold;
    logic [63:0] p_pc;
    logic [31:0] p_inst;
    bit          p_fault;
    bit          e_fault;

    always @(negedge clk) begin
        if (!rst) begin
            exp_pc = BASE;
            outst  = 1'b0;
            idle   = 0;
            p_hold = 1'b0;
        end else begin
            if (imem_ar_valid) begin
                check("ar_addr", imem_ar_addr, exp_pc);
                check("ar_single_outstanding", 64'(outst), 64'd0);
            end
            if (p_hold) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_pc", out_pc, p_pc);
                check("hold_inst", 64'(out_inst), 64'(p_inst));
                check("hold_fault", 64'(out_fault), 64'(p_fault));
            end
            if (out_valid) begin
                idle    = 0;
                e_fault = (exp_pc[1:0] != 2'b00) || errf(exp_pc);
                check("out_pc", out_pc, exp_pc);
                check("out_fault", 64'(out_fault), 64'(e_fault));
                check("out_inst", 64'(out_inst), e_fault ? 64'd0 : 64'(memf(exp_pc)));
            end else begin
                idle++;
                if (idle > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL liveness: no out_valid for %0d cycles, required at most 200", idle);
                    idle = 0;
                end
            end
            p_hold  = out_valid && !out_ready && !redirect_valid;
            p_pc    = out_pc;
            p_inst  = out_inst;
            p_fault = out_fault;
            if (imem_r_valid && imem_r_ready) outst = 1'b0;
            if (imem_ar_valid && imem_ar_ready) outst = 1'b1;
            if (redirect_valid) begin
                exp_pc = redirect_pc;
            end else if (out_valid && out_ready) begin
                exp_pc = exp_pc + 64'd4;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ar(input string name);
        int n = 0;
        while (!imem_ar_valid && n < 40) begin
            step();
            n++;
        end
        check(name, 64'(imem_ar_valid), 64'd1);
    endtask

    task automatic wait_out(input string name, output bit saw_ar);
        int n = 0;
        saw_ar = 1'b0;
        while (!out_valid && n < 40) begin
            step();
            n++;
            if (imem_ar_valid) saw_ar = 1'b1;
        end
        check(name, 64'(out_valid), 64'd1);
    endtask

    initial begin
        bit          saw;
        int          n;
        int          r;
        logic [63:0] off;

        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ar_valid", 64'(imem_ar_valid), 64'd0);
        check("rst_r_ready", 64'(imem_r_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_inst", 64'(out_inst), 64'd0);
        check("rst_out_fault", 64'(out_fault), 64'd0);
        rst = 1'b1;

        // Zero-wait streaming: request on cycles 1,4,7, output on 3,6,9.
        for (int c = 1; c <= 9; c++) begin
            step();
            check("t1_ar_valid", 64'(imem_ar_valid), 64'(c % 3 == 1));
            if (c % 3 == 1) check("t1_ar_addr", imem_ar_addr, 64'h8000_0000 + 64'(4 * (c / 3)));
            check("t1_out_valid", 64'(out_valid), 64'(c % 3 == 0));
            if (c % 3 == 0) begin
                check("t1_out_pc", out_pc, 64'h8000_0000 + 64'(4 * (c / 3 - 1)));
                check("t1_out_inst", 64'(out_inst), 64'(memf(64'h8000_0000 + 64'(4 * (c / 3 - 1)))));
            end
        end
        check("t1_lit_inst0", 64'(memf(64'h8000_0000)), 64'h0000_0000_DA5A_43C3);

        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("t2_valid", 64'(out_valid), 64'd1);
            check("t2_pc", out_pc, 64'h8000_0008);
            check("t2_inst", 64'(out_inst), 64'(memf(64'h8000_0008)));
            check("t2_no_ar", 64'(imem_ar_valid), 64'd0);
        end
        out_ready = 1'b1;
        mem_delay = 2;
        step();
        check("t2_next_ar_valid", 64'(imem_ar_valid), 64'd1);
        check("t2_next_ar_addr", imem_ar_addr, 64'h8000_000C);

        step();
        check("t3_in_wait", 64'(imem_r_ready), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        step();
        redirect_valid = 1'b0;
        mem_delay      = 0;
        check("t3_no_out_after_redirect", 64'(out_valid), 64'd0);
        wait_ar("t3_ar_seen");
        check("t3_ar_addr", imem_ar_addr, 64'h8000_0100);
        wait_out("t3_out_seen", saw);
        check("t3_out_pc", out_pc, 64'h8000_0100);
        check("t3_out_inst", 64'(out_inst), 64'(memf(64'h8000_0100)));

        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        step();
        redirect_valid = 1'b0;
        wait_ar("t4_ar_seen");
        check("t4_ar_addr", imem_ar_addr, 64'h8000_0200);
        wait_out("t4_out_seen", saw);
        check("t4_out_pc", out_pc, 64'h8000_0200);

        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0102;
        step();
        redirect_valid = 1'b0;
        check("t5_no_ar_first", 64'(imem_ar_valid), 64'd0);
        wait_out("t5_out_seen", saw);
        check("t5_no_ar", 64'(saw), 64'd0);
        check("t5_out_pc", out_pc, 64'h8000_0102);
        check("t5_out_fault", 64'(out_fault), 64'd1);
        check("t5_out_inst", 64'(out_inst), 64'd0);

        err_addr       = 64'h8000_0004;
        redirect_valid = 1'b1;
        redirect_pc    = BASE;
        step();
        redirect_valid = 1'b0;
        wait_out("t6_first_seen", saw);
        check("t6_first_pc", out_pc, 64'h8000_0000);
        check("t6_first_fault", 64'(out_fault), 64'd0);
        step();
        wait_out("t6_err_seen", saw);
        check("t6_err_pc", out_pc, 64'h8000_0004);
        check("t6_err_fault", 64'(out_fault), 64'd1);
        check("t6_err_inst", 64'(out_inst), 64'd0);
        mem_delay = 3;
        step();
        n = 0;
        while (!imem_r_ready && n < 40) begin
            step();
            n++;
        end
        check("t6_reached_wait", 64'(imem_r_ready), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_ar_valid", 64'(imem_ar_valid), 64'd0);
        check("t6_rst_r_ready", 64'(imem_r_ready), 64'd0);
        check("t6_rst_out_valid", 64'(out_valid), 64'd0);
        check("t6_rst_out_pc", out_pc, 64'd0);
        check("t6_rst_out_inst", 64'(out_inst), 64'd0);
        check("t6_rst_out_fault", 64'(out_fault), 64'd0);
        mem_delay = 0;
        step();
        step();
        rst = 1'b1;
        wait_ar("t6_refetch_seen");
        check("t6_refetch_addr", imem_ar_addr, 64'h8000_0000);
        wait_out("t6_refetch_out", saw);
        check("t6_refetch_pc", out_pc, 64'h8000_0000);
        check("t6_refetch_fault", 64'(out_fault), 64'd0);

        // Randomized traffic: memory stalls, back-pressure, redirects, errors.
        rst         = 1'b0;
        rand_mem    = 1'b1;
        err_rand_en = 1'b1;
        err_addr    = 64'h8000_0040;
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                redirect_valid = 1'b1;
                r   = int'($urandom_range(0, 99));
                off = 64'($urandom_range(0, 63)) << 2;
                if (r < 5) begin
                    redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
                end else if (r < 15) begin
                    redirect_pc = BASE + off + 64'd2;
                end else begin
                    redirect_pc = BASE + off;
                end
            end else begin
                redirect_valid = 1'b0;
            end
            step();
        end
        redirect_valid = 1'b0;
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
